stopwatch_control: RTL and testbench
====================================

# stopwatch_control

Run/stop/lap/clear controller for the stopwatch. Sits between the board push-buttons and the BCD counter chain, and between the counter outputs and the 4-digit display driver. Conditions three raw buttons and gates the 1 Hz tick into the seconds-units counter enable. Issues a clear pulse to all four counters. Supplies the display with either the live time or a frozen lap snapshot.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive identical synchronized samples (10 ms at 100 MHz) required before a button level is accepted.
- DIGITS, 4: number of BCD digits in the time bus.
- clk  in  1  board clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle 1 Hz pulse from the one-second clock generator.
- btn_start_stop  in  1  raw, asynchronous, active-high push-button.
- btn_lap  in  1  raw, asynchronous, active-high push-button.
- btn_clear  in  1  raw, asynchronous, active-high push-button.
- time_in  in  4*DIGITS  live BCD time from the counters, {min10, min1, sec10, sec1}.
- count_enable  out  1  enable for the seconds-units counter.
- counter_clear  out  1  one-cycle pulse that resets all counters to 0.
- display_time  out  4*DIGITS  BCD value presented to the display driver.
- running  out  1  high in RUNNING or LAP; drives a status LED.
- lap_active  out  1  high while the display is frozen (LAP).

## Operation
- Button conditioning, per button:
  - Raw input passes through a 2-flop synchronizer.
  - A debounce counter accepts a new level after DEBOUNCE_CYCLES consecutive equal samples; any differing sample restarts the count.
  - A rising edge of the accepted level produces a one-cycle press pulse.
  - Falling edges produce nothing; a held button yields exactly one pulse.
- States: IDLE, RUNNING, LAP, STOPPED. Reset state is IDLE.
- Transitions:
  - IDLE: start_stop → RUNNING. lap and clear are ignored.
  - RUNNING: start_stop → STOPPED. lap → LAP and latches time_in into lap_reg. clear is ignored.
  - LAP: lap → RUNNING (display released). start_stop → STOPPED (display released). clear is ignored.
  - STOPPED: start_stop → RUNNING. clear → IDLE and issues counter_clear. lap is ignored.
- Simultaneous press pulses in one cycle: priority is clear > start_stop > lap. Only the highest-priority press that is valid in the current state is acted on; the others are discarded, not queued.
- count_enable = tick AND (state ∈ {RUNNING, LAP}), using the state register value in that cycle. A tick coinciding with a transition is gated by the pre-transition state.
- display_time = lap_reg when state = LAP, otherwise time_in (combinational mux).
- Reset values:
  - state IDLE
  - lap_reg 0
  - counter_clear 0
  - count_enable 0 (state is IDLE)
  - running 0
  - lap_active 0
  - all debounce counters 0
  - all accepted levels 0
  - all sync flops 0
- rst asserted mid-press: the press is lost. A button still held after reset is accepted as a new press once debounced.

## Timing
- Debounce latency: raw high at edge n; synchronizer output high after edge n+2; accepted level rises at edge n+2+DEBOUNCE_CYCLES; press pulse is high for the following cycle; state updates at the edge after that.
- Total: state changes DEBOUNCE_CYCLES+4 edges after raw input rises, for a clean input.
- counter_clear is registered. It is high for exactly one cycle, the cycle after the edge where STOPPED → IDLE is taken.
- lap_reg captures time_in at the same edge where RUNNING → LAP is taken.
- count_enable, running, lap_active and display_time have zero latency relative to the state register.

## Structure
- stopwatch_pkg holds:
  - the state enum (2-bit: IDLE=0, RUNNING=1, LAP=2, STOPPED=3)
  - the BCD digit width constant (4)
  - the button index constants
- Sub-module button_conditioner (synchronizer + debounce counter + rising-edge pulse), parameterized by DEBOUNCE_CYCLES. It is instantiated three times.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES+1). DEBOUNCE_CYCLES ≥ 1.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, with ticks every 20 cycles.
- Reset, then 100 idle cycles with ticks → count_enable, counter_clear and running stay 0; display_time equals time_in.
- Clean start_stop press held 20 cycles → exactly one press pulse; state RUNNING at edge n+8. Each later tick produces count_enable = 1 for that one cycle.
- Raw start_stop bouncing (toggle every 2 cycles for 10 cycles, then stable high) → one press only, no double toggle.
- While RUNNING with time_in = 0x0125, press lap → display_time holds 0x0125 while time_in advances to 0x0130; lap_active = 1; count_enable is still pulsing. Press lap again → display_time follows time_in.
- STOPPED, then clear → counter_clear high for exactly one cycle; state IDLE. Clear pressed in RUNNING or IDLE → no counter_clear.
- clear and lap press pulses in the same cycle while STOPPED → clear wins (IDLE, counter_clear). start_stop and lap in the same cycle while RUNNING → STOPPED, lap_reg unchanged.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/stop/lap/clear controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LAP     = 2'd2,
        ST_STOPPED = 2'd3
    } state_e;

    localparam int BCD_W = 4;

    localparam int NUM_BTNS       = 3;
    localparam int BTN_START_STOP = 0;
    localparam int BTN_LAP        = 1;
    localparam int BTN_CLEAR      = 2;

endpackage

// File: rtl/stopwatch_button_conditioner.sv
// Push-button conditioning: 2-flop synchronizer, debounce counter and
// a one-cycle pulse on each accepted rising edge.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          prev_q;
    logic          press_q, press_d;

    // The count is the run length of samples that disagree with the
    // accepted level; an agreeing sample drops it back to zero.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch controller: conditions the buttons, gates the 1 Hz tick into
// the counter chain, issues counter clears and muxes live/lap display time.
module stopwatch_control
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DIGITS          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      btn_start_stop,
    input  logic                      btn_lap,
    input  logic                      btn_clear,
    input  logic [BCD_W*DIGITS-1:0]   time_in,
    output logic                      count_enable,
    output logic                      counter_clear,
    output logic [BCD_W*DIGITS-1:0]   display_time,
    output logic                      running,
    output logic                      lap_active
);

    localparam int TW = BCD_W * DIGITS;

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press;

    assign btn_raw[BTN_START_STOP] = btn_start_stop;
    assign btn_raw[BTN_LAP]        = btn_lap;
    assign btn_raw[BTN_CLEAR]      = btn_clear;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (btn_raw[i]),
            .press_o(press[i])
        );
    end

    state_e        state_q, state_d;
    logic [TW-1:0] lap_q, lap_d;
    logic          clr_q, clr_d;

    // Within each state the checks run clear, then start_stop, then lap,
    // so only the highest-priority press that means something is taken.
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press[BTN_START_STOP]) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (press[BTN_START_STOP]) begin
                    state_d = ST_STOPPED;
                end else if (press[BTN_LAP]) begin
                    state_d = ST_LAP;
                    lap_d   = time_in;
                end
            end
            ST_LAP: begin
                if (press[BTN_START_STOP]) begin
                    state_d = ST_STOPPED;
                end else if (press[BTN_LAP]) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_STOPPED: begin
                if (press[BTN_CLEAR]) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (press[BTN_START_STOP]) begin
                    state_d = ST_RUNNING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lap_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lap_q   <= lap_d;
            clr_q   <= clr_d;
        end
    end

    assign running       = (state_q == ST_RUNNING) || (state_q == ST_LAP);
    assign lap_active    = (state_q == ST_LAP);
    assign count_enable  = tick & running;
    assign counter_clear = clr_q;
    assign display_time  = lap_active ? lap_q : time_in;

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control: directed tables, corner sequences and random
// button activity against a history-window reference model.
module tb_stopwatch_control;

    localparam int D = 4;
    localparam int W = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LAP  = 2;
    localparam int M_STOP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, tick, b_ss, b_lap, b_clr;
    logic [W-1:0] time_v;
    logic         count_enable, counter_clear, running, lap_active;
    logic [W-1:0] display_time;

    stopwatch_control #(
        .DEBOUNCE_CYCLES(D),
        .DIGITS         (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .btn_start_stop(b_ss),
        .btn_lap       (b_lap),
        .btn_clear     (b_clr),
        .time_in       (time_v),
        .count_enable  (count_enable),
        .counter_clear (counter_clear),
        .display_time  (display_time),
        .running       (running),
        .lap_active    (lap_active)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int clr_seen = 0;
    int ce_seen = 0;

    // Reference model: mode, lap snapshot, clear flag and per-button
    // raw-sample / window / accepted-level histories.
    int           m_mode = M_IDLE;
    logic [W-1:0] m_lap = '0;
    bit           m_clr = 1'b0;
    bit           rr1[3], rr2[3], a1[3], a2[3], a3[3];
    logic [D-1:0] win[3];

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    function automatic bit m_running();
        return (m_mode == M_RUN) || (m_mode == M_LAP);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_lap  = '0;
        m_clr  = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rr1[b] = 0; rr2[b] = 0;
            a1[b] = 0; a2[b] = 0; a3[b] = 0;
            win[b] = '0;
        end
    endtask

    task automatic model_edge();
        bit raw[3];
        bit p[3];
        bit acc;
        raw[0] = b_ss; raw[1] = b_lap; raw[2] = b_clr;
        if (rst) begin
            model_reset();
            chk_en = 1'b1;
            return;
        end
        for (int b = 0; b < 3; b++) p[b] = a2[b] && !a3[b];
        m_clr = 1'b0;
        case (m_mode)
            M_IDLE: if (p[0]) m_mode = M_RUN;
            M_RUN: begin
                if (p[0]) m_mode = M_STOP;
                else if (p[1]) begin
                    m_mode = M_LAP;
                    m_lap  = time_v;
                end
            end
            M_LAP: begin
                if (p[0]) m_mode = M_STOP;
                else if (p[1]) m_mode = M_RUN;
            end
            default: begin
                if (p[2]) begin
                    m_mode = M_IDLE;
                    m_clr  = 1'b1;
                end else if (p[0]) m_mode = M_RUN;
            end
        endcase
        // Accepted level flips once the last D synchronized samples all
        // disagree with it.
        for (int b = 0; b < 3; b++) begin
            win[b] = {win[b][D-2:0], rr2[b]};
            acc = a1[b];
            if (win[b] == {D{!acc}}) acc = !acc;
            a3[b] = a2[b]; a2[b] = a1[b]; a1[b] = acc;
            rr2[b] = rr1[b]; rr1[b] = raw[b];
        end
    endtask

    task automatic cycle();
        tick = (cyc % 20 == 19);
        #1;
        if (chk_en) begin
            check("count_enable", W'(count_enable), W'(tick && m_running()));
            check("counter_clear", W'(counter_clear), W'(m_clr));
            check("running", W'(running), W'(m_running()));
            check("lap_active", W'(lap_active), W'(m_mode == M_LAP));
            check("display_time", display_time,
                  (m_mode == M_LAP) ? m_lap : time_v);
        end
        if (counter_clear) clr_seen++;
        if (count_enable) ce_seen++;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
    endtask

    task automatic press(input logic [2:0] m, input int hold, input int rel,
                         input logic [W-1:0] tp, input logic [W-1:0] ta);
        {b_clr, b_lap, b_ss} = m;
        time_v = tp;
        repeat (hold) cycle();
        {b_clr, b_lap, b_ss} = 3'b000;
        time_v = ta;
        repeat (rel) cycle();
    endtask

    typedef struct {
        logic [2:0]   btn;
        logic [W-1:0] tp;
        logic [W-1:0] ta;
        logic         run;
        logic         lap;
        logic [W-1:0] disp;
        int           clr;
    } vec_t;

    vec_t tbl[15];
    int   hold_left;

    initial begin
        // btn = {clear, lap, start_stop}
        tbl[0]  = '{3'b100, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 0};
        tbl[1]  = '{3'b001, 16'h0100, 16'h0101, 1'b1, 1'b0, 16'h0101, 0};
        tbl[2]  = '{3'b100, 16'h0110, 16'h0120, 1'b1, 1'b0, 16'h0120, 0};
        tbl[3]  = '{3'b010, 16'h0125, 16'h0130, 1'b1, 1'b1, 16'h0125, 0};
        tbl[4]  = '{3'b100, 16'h0131, 16'h0132, 1'b1, 1'b1, 16'h0125, 0};
        tbl[5]  = '{3'b010, 16'h0133, 16'h0134, 1'b1, 1'b0, 16'h0134, 0};
        tbl[6]  = '{3'b011, 16'h0140, 16'h0141, 1'b0, 1'b0, 16'h0141, 0};
        tbl[7]  = '{3'b001, 16'h0142, 16'h0143, 1'b1, 1'b0, 16'h0143, 0};
        tbl[8]  = '{3'b001, 16'h0150, 16'h0151, 1'b0, 1'b0, 16'h0151, 0};
        tbl[9]  = '{3'b110, 16'h0152, 16'h0153, 1'b0, 1'b0, 16'h0153, 1};
        tbl[10] = '{3'b010, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 0};
        tbl[11] = '{3'b001, 16'h0200, 16'h0201, 1'b1, 1'b0, 16'h0201, 0};
        tbl[12] = '{3'b010, 16'h0202, 16'h0203, 1'b1, 1'b1, 16'h0202, 0};
        tbl[13] = '{3'b001, 16'h0204, 16'h0205, 1'b0, 1'b0, 16'h0205, 0};
        tbl[14] = '{3'b101, 16'h0206, 16'h0207, 1'b0, 1'b0, 16'h0207, 1};

        rst = 1'b1; tick = 1'b0;
        b_ss = 1'b0; b_lap = 1'b0; b_clr = 1'b0;
        time_v = 16'h0042;
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        check("rst_running", W'(running), W'(0));
        check("rst_lap_active", W'(lap_active), W'(0));
        check("rst_counter_clear", W'(counter_clear), W'(0));
        ce_seen = 0; clr_seen = 0;
        repeat (100) cycle();
        check("idle_ce_count", W'(ce_seen), W'(0));
        check("idle_clr_count", W'(clr_seen), W'(0));
        check("idle_display", display_time, 16'h0042);

        // Clean press: first sampled at edge E0, state changes at E0+7.
        b_ss = 1'b1;
        repeat (7) cycle();
        check("start_before_latency", W'(running), W'(0));
        cycle();
        check("start_at_latency", W'(running), W'(1));
        repeat (12) cycle();
        b_ss = 1'b0;
        repeat (12) cycle();
        check("start_single_press", W'(running), W'(1));
        ce_seen = 0;
        repeat (40) cycle();
        check("running_tick_count", W'(ce_seen), W'(2));

        press(3'b001, 10, 12, 16'h0000, 16'h0000);
        check("stop_running", W'(running), W'(0));
        clr_seen = 0;
        press(3'b100, 10, 12, 16'h0000, 16'h0000);
        check("clear_pulse_count", W'(clr_seen), W'(1));

        // Bouncing start_stop: must give a single press only.
        for (int i = 0; i < 5; i++) begin
            b_ss = (i % 2 == 0);
            repeat (2) cycle();
        end
        b_ss = 1'b1;
        repeat (20) cycle();
        b_ss = 1'b0;
        repeat (12) cycle();
        check("bounce_running", W'(running), W'(1));
        press(3'b001, 10, 12, 16'h0000, 16'h0000);
        clr_seen = 0;
        press(3'b100, 10, 12, 16'h0000, 16'h0000);
        check("bounce_back_idle", W'(running | counter_clear), W'(0));

        for (int v = 0; v < 15; v++) begin
            clr_seen = 0;
            press(tbl[v].btn, 10, 12, tbl[v].tp, tbl[v].ta);
            check($sformatf("tbl%0d_running", v), W'(running), W'(tbl[v].run));
            check($sformatf("tbl%0d_lap", v), W'(lap_active), W'(tbl[v].lap));
            check($sformatf("tbl%0d_display", v), display_time, tbl[v].disp);
            check($sformatf("tbl%0d_clr", v), W'(clr_seen), W'(tbl[v].clr));
        end

        hold_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_left == 0) begin
                b_ss  = ($urandom_range(0, 2) == 0);
                b_lap = ($urandom_range(0, 2) == 0);
                b_clr = ($urandom_range(0, 2) == 0);
                hold_left = $urandom_range(1, 14);
            end
            hold_left--;
            if ($urandom_range(0, 15) == 0) time_v = W'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst = 1'b0;
        b_ss = 1'b0; b_lap = 1'b0; b_clr = 1'b0;
        repeat (20) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
